// File: rtl/vji_pkg.sv
// Shared IR codes, IR type and STAT field layout for the virtual-JTAG DSKY bridge.
// Constants and helpers only; no latency or backpressure of its own.
package vji_pkg;

    typedef logic [2:0] vji_ir_t;

    localparam vji_ir_t IR_SEL  = 3'b001;
    localparam vji_ir_t IR_POP  = 3'b010;
    localparam vji_ir_t IR_KEY  = 3'b011;
    localparam vji_ir_t IR_STAT = 3'b100;
    localparam vji_ir_t IR_NOP  = 3'b111;

    localparam int PAR_CNT_W    = 8;
    localparam int STAT_CNT_OFS = 0;

    // The STAT word is {par_err_cnt, key_ovf, key_count} packed from bit 0 upward.
    function automatic int stat_ovf_ofs(input int cnt_w);
        return STAT_CNT_OFS + cnt_w;
    endfunction

    function automatic int stat_par_ofs(input int cnt_w);
        return stat_ovf_ofs(cnt_w) + 1;
    endfunction

    // Unlisted IR codes behave as NOP, so only the four real instructions shift.
    function automatic logic ir_shifts(input vji_ir_t ir);
        return (ir == IR_SEL) || (ir == IR_POP) || (ir == IR_KEY) || (ir == IR_STAT);
    endfunction

endpackage

// File: rtl/vji_key_fifo.sv
// Keycode FIFO with occupancy count; head reads 0 when empty.
// Head is visible the cycle after a push; a push when full is dropped unless a pop shares the cycle.
module vji_key_fifo #(
    parameter int KEY_W     = 5,
    parameter int KEY_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               push,
    input  logic [KEY_W-1:0]                   push_data,
    input  logic                               pop,
    output logic [KEY_W-1:0]                   head,
    output logic                               empty,
    output logic [$clog2(KEY_DEPTH+1)-1:0]     count,
    output logic                               drop
);

    localparam int PTR_W = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
    localparam int CNT_W = $clog2(KEY_DEPTH + 1);

    logic [KEY_W-1:0] mem [KEY_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop_en;
    logic             push_en;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(KEY_DEPTH));
    assign pop_en  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    assign push_en = push & (~full | pop_en);
    assign drop    = push & full & ~pop_en;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vji_dsky_bridge.sv
// Virtual-JTAG DSKY bridge: tap signals oversampled in clk; select/test, read-back and key FIFO (VJI_KEY_PARITY_EN adds key parity).
// tdo follows a tck edge within 4 clk; key FIFO pops on key_valid & key_ready and drops pushes when full.
module vji_dsky_bridge #(
    parameter int DATA_W    = 8,
    parameter int SEL_W     = 4,
    parameter int KEY_W     = 5,
    parameter int KEY_DEPTH = 4,
    parameter int N_RD      = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           tck,
    input  logic                           tdi,
    input  logic [2:0]                     ir_in,
    input  logic                           cdr,
    input  logic                           sdr,
    input  logic                           udr,
    output logic                           tdo,
    input  logic [N_RD*DATA_W-1:0]         rd_data,
    output logic [SEL_W-1:0]               sel_out,
    output logic                           test_out,
    output logic [KEY_W-1:0]               key_data,
    output logic                           key_valid,
    input  logic                           key_ready,
    output logic                           key_ovf,
    output logic [$clog2(KEY_DEPTH+1)-1:0] key_count
);

    import vji_pkg::*;

    localparam int CNT_W   = $clog2(KEY_DEPTH + 1);
    localparam int OVF_OFS = stat_ovf_ofs(CNT_W);
`ifdef VJI_KEY_PARITY_EN
    localparam int STAT_W  = stat_par_ofs(CNT_W) + PAR_CNT_W;
`else
    localparam int STAT_W  = OVF_OFS + 1;
`endif
    localparam int SYNC_W  = 8;

    logic [SYNC_W-1:0] sync_q1;
    logic [SYNC_W-1:0] sync_q2;
    logic              tck_s, tdi_s, cdr_s, sdr_s, udr_s;
    vji_ir_t           ir_s;
    logic              tck_d, udr_d;
    logic              tck_rise, udr_rise;

    logic [DATA_W-1:0]        shreg;
    logic [DATA_W-1:0]        rd_sel;
    logic [STAT_W-1:0]        stat_raw;
    logic [STAT_W+DATA_W-1:0] stat_ext;
    logic [DATA_W-1:0]        stat_vec;
    logic                     stat_capture;
    logic                     key_push;
    logic                     key_drop;

    // All tap inputs share one two-stage chain so they stay aligned with the sampled tck.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            tck_d   <= 1'b0;
            udr_d   <= 1'b0;
        end else begin
            sync_q1 <= {tck, tdi, cdr, sdr, udr, ir_in};
            sync_q2 <= sync_q1;
            tck_d   <= tck_s;
            udr_d   <= udr_s;
        end
    end

    assign {tck_s, tdi_s, cdr_s, sdr_s, udr_s, ir_s} = sync_q2;
    assign tck_rise = tck_s & ~tck_d;
    assign udr_rise = udr_s & ~udr_d;

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < N_RD; k++) begin
            if (int'(sel_out) == k) rd_sel = rd_data[k*DATA_W +: DATA_W];
        end
    end

`ifdef VJI_KEY_PARITY_EN
    logic                 key_par_ok;
    logic                 par_err;
    logic [PAR_CNT_W-1:0] par_err_cnt;

    // Odd parity: the keycode plus its parity bit must hold an odd number of ones.
    assign key_par_ok = ^shreg[KEY_W:0];
    assign key_push   = udr_rise & (ir_s == IR_KEY) & key_par_ok;
    assign par_err    = udr_rise & (ir_s == IR_KEY) & ~key_par_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err_cnt <= '0;
        end else if (stat_capture) begin
            par_err_cnt <= par_err ? PAR_CNT_W'(1) : '0;
        end else if (par_err && (par_err_cnt != '1)) begin
            par_err_cnt <= par_err_cnt + PAR_CNT_W'(1);
        end
    end
`else
    assign key_push = udr_rise & (ir_s == IR_KEY);
`endif

    always_comb begin
        stat_raw = '0;
        stat_raw[STAT_CNT_OFS +: CNT_W] = key_count;
        stat_raw[OVF_OFS] = key_ovf;
`ifdef VJI_KEY_PARITY_EN
        stat_raw[stat_par_ofs(CNT_W) +: PAR_CNT_W] = par_err_cnt;
`endif
    end

    // Pad then slice so the status word is zero-extended or truncated to DATA_W alike.
    assign stat_ext     = {{DATA_W{1'b0}}, stat_raw};
    assign stat_vec     = stat_ext[DATA_W-1:0];
    assign stat_capture = tck_rise & cdr_s & (ir_s == IR_STAT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
        end else if (tck_rise) begin
            if (cdr_s) begin
                if (ir_s == IR_POP)       shreg <= rd_sel;
                else if (ir_s == IR_STAT) shreg <= stat_vec;
            end else if (sdr_s && ir_shifts(ir_s)) begin
                shreg <= {tdi_s, shreg[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tdo      <= 1'b0;
            sel_out  <= '0;
            test_out <= 1'b0;
            key_ovf  <= 1'b0;
        end else begin
            tdo <= shreg[0];
            if (udr_rise && (ir_s == IR_SEL)) begin
                sel_out  <= shreg[SEL_W-1:0];
                test_out <= shreg[DATA_W-1];
            end
            // A drop in the capture cycle wins so an overflow is never lost to read-clear.
            if (key_drop)          key_ovf <= 1'b1;
            else if (stat_capture) key_ovf <= 1'b0;
        end
    end

    logic fifo_empty;

    vji_key_fifo #(
        .KEY_W     (KEY_W),
        .KEY_DEPTH (KEY_DEPTH)
    ) u_key_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (key_push),
        .push_data (shreg[KEY_W-1:0]),
        .pop       (key_ready),
        .head      (key_data),
        .empty     (fifo_empty),
        .count     (key_count),
        .drop      (key_drop)
    );

    assign key_valid = ~fifo_empty;

endmodule

// File: tb/tb_vji_dsky_bridge.sv
// Self-checking bench for vji_dsky_bridge driving the virtual tap at 1/16 of clk.
// Expected values come from a queue/register model of the DSKY console behaviour.
module tb_vji_dsky_bridge;

    localparam int DATA_W    = 8;
    localparam int SEL_W     = 4;
    localparam int KEY_W     = 5;
    localparam int KEY_DEPTH = 4;
    localparam int N_RD      = 2;

    localparam logic [2:0] C_SEL  = 3'b001;
    localparam logic [2:0] C_POP  = 3'b010;
    localparam logic [2:0] C_KEY  = 3'b011;
    localparam logic [2:0] C_STAT = 3'b100;

    logic clk = 1'b0;
    logic reset_n, tck, tdi, cdr, sdr, udr, key_ready;
    logic [2:0] ir_in;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic tdo, test_out, key_valid, key_ovf;
    logic [SEL_W-1:0] sel_out;
    logic [KEY_W-1:0] key_data;
    logic [2:0] key_count;

    int checks = 0;
    int failures = 0;

    logic [SEL_W-1:0] m_sel;
    logic             m_test;
    logic             m_ovf;
    logic [KEY_W-1:0] m_q[$];

    vji_dsky_bridge #(
        .DATA_W(DATA_W), .SEL_W(SEL_W), .KEY_W(KEY_W), .KEY_DEPTH(KEY_DEPTH), .N_RD(N_RD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tck(tck), .tdi(tdi), .ir_in(ir_in),
        .cdr(cdr), .sdr(sdr), .udr(udr), .tdo(tdo), .rd_data(rd_data),
        .sel_out(sel_out), .test_out(test_out), .key_data(key_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_ovf(key_ovf),
        .key_count(key_count)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tck_cycle();
        tck = 1'b1; wait_clk(8);
        tck = 1'b0; wait_clk(8);
    endtask

    // Full DR scan: capture, DATA_W shifts (tdo sampled before each shift edge), optional update.
    task automatic dr_scan(input logic [2:0] ir, input logic [DATA_W-1:0] din,
                           input bit do_udr, output logic [DATA_W-1:0] dout);
        ir_in = ir; wait_clk(4);
        cdr = 1'b1; tck_cycle(); cdr = 1'b0;
        sdr = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
            tdi = din[i];
            dout[i] = tdo;
            tck_cycle();
        end
        sdr = 1'b0;
        if (do_udr) begin
            udr = 1'b1; wait_clk(4); udr = 1'b0; wait_clk(4);
        end
    endtask

    function automatic logic [DATA_W-1:0] key_word(input logic [KEY_W-1:0] code);
        logic [DATA_W-1:0] w;
        w = DATA_W'($urandom);
        w[KEY_W-1:0] = code;
        w[KEY_W] = ~(^code);
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] exp_pop(input logic [SEL_W-1:0] s, input logic [N_RD*DATA_W-1:0] rd);
        logic [DATA_W-1:0] ch [N_RD];
        for (int k = 0; k < N_RD; k++) ch[k] = rd[k*DATA_W +: DATA_W];
        return (int'(s) < N_RD) ? ch[int'(s)] : '0;
    endfunction

    task automatic sel_scan(input logic [DATA_W-1:0] din);
        logic [DATA_W-1:0] d;
        dr_scan(C_SEL, din, 1'b1, d);
        m_sel = din[SEL_W-1:0];
        m_test = din[DATA_W-1];
    endtask

    task automatic push_key(input logic [KEY_W-1:0] code);
        logic [DATA_W-1:0] d;
        dr_scan(C_KEY, key_word(code), 1'b1, d);
        if (m_q.size() == KEY_DEPTH) m_ovf = 1'b1;
        else m_q.push_back(code);
    endtask

    task automatic pop_one(input string name);
        logic [KEY_W-1:0] e;
        e = (m_q.size() > 0) ? m_q[0] : '0;
        checks++;
        if (key_data !== e || key_valid !== (m_q.size() > 0)) begin
            failures++;
            $display("FAIL %s head got=%h/v%b exp=%h/v%b", name, key_data, key_valid, e, m_q.size() > 0);
        end
        key_ready = 1'b1; wait_clk(1); key_ready = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic stat_scan(input string name);
        logic [DATA_W-1:0] d, e;
        dr_scan(C_STAT, DATA_W'($urandom), 1'b1, d);
        e = {4'b0, m_ovf, 3'(m_q.size())};
        m_ovf = 1'b0;
        checks++;
        if (d !== e) begin failures++; $display("FAIL %s stat got=%h exp=%h", name, d, e); end
        checks++;
        if (key_ovf !== 1'b0) begin failures++; $display("FAIL %s ovf_clr got=%b exp=0", name, key_ovf); end
    endtask

    task automatic check_fifo(input string name);
        checks++;
        if (key_count !== 3'(m_q.size()) || key_ovf !== m_ovf || key_valid !== (m_q.size() > 0)) begin
            failures++;
            $display("FAIL %s fifo got cnt=%0d ovf=%b v=%b exp cnt=%0d ovf=%b", name,
                     key_count, key_ovf, key_valid, m_q.size(), m_ovf);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tck = 1'b0; tdi = 1'b1; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
        ir_in = 3'b111; key_ready = 1'b0; rd_data = 16'hBEEF;
        m_sel = '0; m_test = 1'b0; m_ovf = 1'b0; m_q.delete();
        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(4);
        checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL rst_tdo got=%b exp=0", tdo); end
        checks++; if (sel_out !== '0) begin failures++; $display("FAIL rst_sel got=%h exp=0", sel_out); end
        checks++; if (test_out !== 1'b0) begin failures++; $display("FAIL rst_test got=%b exp=0", test_out); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", key_valid); end
        checks++; if (key_count !== '0) begin failures++; $display("FAIL rst_count got=%0d exp=0", key_count); end
        checks++; if (key_ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", key_ovf); end
        checks++; if (key_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", key_data); end
    endtask

    task automatic test_sel();
        logic [DATA_W-1:0] d;
        sel_scan(8'h85);
        checks++;
        if (sel_out !== m_sel || test_out !== m_test) begin
            failures++; $display("FAIL sel_85 got=%h/%b exp=%h/%b", sel_out, test_out, m_sel, m_test);
        end
        rd_data = 16'(($urandom));
        dr_scan(C_POP, 8'hFF, 1'b1, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL pop_oob got=%h exp=00", d); end
        checks++;
        if (sel_out !== 4'h5 || test_out !== 1'b1) begin
            failures++; $display("FAIL sel_hold got=%h/%b exp=5/1", sel_out, test_out);
        end
        for (int i = 0; i < 4; i++) begin
            sel_scan(DATA_W'($urandom));
            checks++;
            if (sel_out !== m_sel || test_out !== m_test) begin
                failures++; $display("FAIL sel_rand%0d got=%h/%b exp=%h/%b", i, sel_out, test_out, m_sel, m_test);
            end
        end
    endtask

    task automatic test_pop();
        logic [DATA_W-1:0] d, e;
        sel_scan(8'h01);
        rd_data = {8'h3C, 8'hA1};
        dr_scan(C_POP, DATA_W'($urandom), 1'b1, d);
        checks++;
        if (d !== 8'h3C) begin failures++; $display("FAIL pop_3c got=%h exp=3c", d); end
        for (int i = 0; i < 6; i++) begin
            sel_scan({DATA_W'($urandom) & 8'hF0} | DATA_W'($urandom_range(0, 3)));
            rd_data = 16'($urandom);
            e = exp_pop(m_sel, rd_data);
            dr_scan(C_POP, DATA_W'($urandom), 1'b1, d);
            checks++;
            if (d !== e || sel_out !== m_sel) begin
                failures++; $display("FAIL pop_rand%0d got=%h sel=%h exp=%h sel=%h", i, d, sel_out, e, m_sel);
            end
        end
    endtask

    task automatic test_key_fifo();
        for (int c = 1; c <= 5; c++) push_key(KEY_W'(c));
        check_fifo("key_overflow");
        checks++;
        if (key_count !== 3'd4 || key_ovf !== 1'b1 || key_data !== 5'd1) begin
            failures++; $display("FAIL key_full got cnt=%0d ovf=%b head=%h exp 4/1/01", key_count, key_ovf, key_data);
        end
        stat_scan("stat_first");
        stat_scan("stat_second");
        for (int i = 0; i < 4; i++) pop_one($sformatf("key_pop%0d", i));
        check_fifo("key_drained");
        pop_one("pop_empty");
        check_fifo("pop_empty_cnt");
    endtask

    task automatic test_push_pop_full();
        logic [DATA_W-1:0] d;
        logic [KEY_W-1:0] code;
        for (int i = 0; i < KEY_DEPTH; i++) push_key(KEY_W'($urandom));
        check_fifo("pp_fill");
        code = KEY_W'($urandom);
        dr_scan(C_KEY, key_word(code), 1'b0, d);
        // udr passes two sync stages; its rising edge lands on the third clk edge.
        udr = 1'b1; wait_clk(2);
        key_ready = 1'b1; wait_clk(1); key_ready = 1'b0;
        wait_clk(2); udr = 1'b0; wait_clk(4);
        void'(m_q.pop_front());
        m_q.push_back(code);
        check_fifo("pp_same_cycle");
        for (int i = 0; i < KEY_DEPTH; i++) pop_one($sformatf("pp_drain%0d", i));
        check_fifo("pp_empty");
    endtask

    task automatic test_random_keys();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) push_key(KEY_W'($urandom));
            else pop_one($sformatf("rnd_pop%0d", i));
            check_fifo($sformatf("rnd_op%0d", i));
        end
        stat_scan("rnd_stat");
        while (m_q.size() > 0) pop_one("rnd_drain");
        check_fifo("rnd_end");
    endtask

    task automatic test_reset_mid_shift();
        logic [DATA_W-1:0] d;
        push_key(5'h11);
        push_key(5'h07);
        sel_scan(8'h8A);
        ir_in = C_KEY; wait_clk(4);
        cdr = 1'b1; tck_cycle(); cdr = 1'b0;
        sdr = 1'b1; tdi = 1'b1; tck_cycle(); tck = 1'b1; wait_clk(3);
        reset_n = 1'b0;
        wait_clk(2);
        tck = 1'b0; sdr = 1'b0;
        m_q.delete(); m_ovf = 1'b0; m_sel = '0; m_test = 1'b0;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(4);
        check_fifo("mid_rst_fifo");
        checks++;
        if (sel_out !== '0 || test_out !== 1'b0 || tdo !== 1'b0 || key_data !== '0) begin
            failures++; $display("FAIL mid_rst_out got sel=%h t=%b tdo=%b d=%h exp 0", sel_out, test_out, tdo, key_data);
        end
        sel_scan(8'h03);
        checks++;
        if (sel_out !== m_sel || test_out !== m_test) begin
            failures++; $display("FAIL post_rst_sel got=%h/%b exp=%h/%b", sel_out, test_out, m_sel, m_test);
        end
        dr_scan(C_STAT, 8'h00, 1'b1, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL post_rst_stat got=%h exp=00", d); end
    endtask

    initial begin
        test_reset();
        test_sel();
        test_pop();
        test_key_fifo();
        test_push_pop_full();
        test_random_keys();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
